fir_mac_writeback: RTL and testbench
====================================

Name: fir_mac_writeback

Overview:
- Sequential FIR engine that owns the initiating side of the processor register file's FIR write port (fir_we / fir_waddr / fir_wdata).
- Accepts one input sample per handshake and shifts it into a delay line. Runs a one-tap-per-cycle signed multiply-accumulate against a loadable coefficient bank.
- Issues a single-cycle write of the filtered result into a chosen architectural register.
- Sits beside the Decode stage. The register file gives the FIR write priority over the core write, so this block never sees backpressure on writeback.

Parameters:
- MAX_TAPS, 8, coefficient bank and delay-line depth; power of two, at least 2.
- DATA_W, 32, width of samples, coefficients and the written result.
- ACC_W, 64, accumulator width; signed, wrapping.
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before truncation to DATA_W.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- coef_we, input, 1, coefficient write strobe.
- coef_addr, input, clog2(MAX_TAPS), coefficient index.
- coef_wdata, input, DATA_W, signed coefficient value.
- taps_cfg, input, clog2(MAX_TAPS)+1, number of taps for this sample.
- sample_valid, input, 1, sample offered.
- sample_ready, output, 1, engine can accept a sample.
- sample_data, input, DATA_W, signed sample.
- dest_reg, input, 5, destination register index; latched with the sample.
- fir_we, output, 1, register-file write strobe.
- fir_waddr, output, 5, register-file write address.
- fir_wdata, output, DATA_W, register-file write data.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when a sample's processing completes.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All delay-line entries and coefficients are cleared to 0; accumulator and tap index to 0.
  - fir_we=0, fir_waddr=0, fir_wdata=0, done=0, busy=0.
  - sample_ready is 0 while reset is asserted and 1 in the first cycle after release.
  - Reset asserted in any state aborts that state: no fir_we and no done are issued.
- FSM states: IDLE, MAC, WRITE.
- sample_ready = (state==IDLE). The handshake fires when sample_valid && sample_ready at a rising edge (E0).
- At E0:
  - d[0]<=sample_data and d[i]<=d[i-1] for all i>0.
  - dest_reg is latched, taps_cfg is latched as T, acc<=0, idx<=0.
  - FSM goes to MAC.
- taps_cfg clamping: 0 is treated as 1; values above MAX_TAPS are treated as MAX_TAPS.
- MAC:
  - Each edge performs acc <= acc + sext(coef[idx]) * sext(d[idx]) and idx <= idx+1.
  - After T edges (E1..ET) the FSM goes to WRITE.
- WRITE (the cycle following ET):
  - fir_we=1, fir_waddr=latched dest, fir_wdata=(acc>>>OUT_SHIFT)[DATA_W-1:0], done=1, all for exactly one cycle.
  - The FSM returns to IDLE at edge ET+1.
  - Handshake-to-fir_we latency is T+1 cycles. Throughput is one sample per T+2 cycles.
- Destination x0: fir_we stays 0 and no other output changes, but done still pulses and timing is unchanged.
- fir_waddr and fir_wdata hold their last values when fir_we=0.
- Arithmetic: the product is a full-width 2*DATA_W signed value, sign-extended to ACC_W. Accumulator overflow wraps. Truncation is not saturated.
- Coefficient writes:
  - coef_we takes effect only in IDLE and is silently dropped when busy.
  - When a coef_we and a sample handshake coincide in IDLE, the write lands at E0 and the MAC for that sample uses the new coefficient.
- The delay line is not cleared between samples; history persists until reset.

Decomposition:
- Shared package fir_pkg holds:
  - the FSM state enum (IDLE/MAC/WRITE);
  - MAX_TAPS, DATA_W and ACC_W defaults;
  - the REG_X0 constant (5'd0).
- One natural sub-module, fir_mac_unit: signed DATA_W x DATA_W multiply plus ACC_W accumulate with clear and enable.
- The coefficient bank, delay line and FSM stay in the top level.

Test Plan:
- Coefs [1,2,3,4], taps_cfg=4, dest=5; samples 10, 20, 30 in turn:
  - fir_we with x5 = 10, then 40, then 100;
  - each write 5 cycles after its handshake;
  - done coincides with each write.
- Signed case: coef[0]=-3, taps_cfg=1, sample 7, dest=9 -> fir_wdata=0xFFFFFFEB on x9, 2 cycles after the handshake.
- dest=0 with a nonzero result -> fir_we never asserts, done pulses once, sample_ready returns after T+2 cycles.
- coef_we to index 0 with value 99 while busy, followed by a sample of 1 at taps=1 -> the result uses the old coef[0], proving the write was dropped.
- Reset asserted at cycle 2 of a 4-tap MAC:
  - no fir_we and no done;
  - sample_ready=1 in the cycle after reset releases;
  - next sample 5 with coef 0 (cleared) gives result 0.
- taps_cfg=0 gives 1-tap behaviour; taps_cfg=15 with MAX_TAPS=8 gives exactly 8 MAC cycles (fir_we at +9).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR writeback engine.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } fir_state_t;

  localparam int FIR_MAX_TAPS = 8;
  localparam int FIR_DATA_W   = 32;
  localparam int FIR_ACC_W    = 64;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: acc_next is the sum the register takes on an enabled edge.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int ACC_W  = FIR_ACC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  acc_next
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    acc_reg;

  // Full-width product, sign-extended into the wrapping accumulator.
  assign product  = coef * sample;
  assign acc_next = acc_reg + ACC_W'(product);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/fir_mac_writeback.sv
// Sequential FIR engine: shifts in a sample, runs one tap per cycle, then writes
// the filtered result into the register file through the FIR write port.
module fir_mac_writeback
  import fir_pkg::*;
#(
  parameter int MAX_TAPS  = FIR_MAX_TAPS,
  parameter int DATA_W    = FIR_DATA_W,
  parameter int ACC_W     = FIR_ACC_W,
  parameter int OUT_SHIFT = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          coef_we,
  input  logic [$clog2(MAX_TAPS)-1:0]   coef_addr,
  input  logic signed [DATA_W-1:0]      coef_wdata,
  input  logic [$clog2(MAX_TAPS):0]     taps_cfg,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic signed [DATA_W-1:0]      sample_data,
  input  logic [4:0]                    dest_reg,
  output logic                          fir_we,
  output logic [4:0]                    fir_waddr,
  output logic [DATA_W-1:0]             fir_wdata,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(MAX_TAPS);
  localparam logic [IDX_W:0] MAX_TAPS_L = (IDX_W+1)'(MAX_TAPS);
  localparam logic [IDX_W:0] ONE_L      = (IDX_W+1)'(1);

  fir_state_t               state_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [IDX_W-1:0]         last_reg;
  logic [IDX_W-1:0]         last_next;
  logic [4:0]               dest_hold_reg;
  logic                     fir_we_reg;
  logic [4:0]               fir_waddr_reg;
  logic [DATA_W-1:0]        fir_wdata_reg;
  logic                     done_reg;
  logic                     handshake;
  logic                     coef_write;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DATA_W-1:0] delay_arr [MAX_TAPS];
  logic signed [DATA_W-1:0] coef_arr  [MAX_TAPS];

  assign sample_ready = (state_reg == IDLE) && !reset;
  assign busy         = (state_reg != IDLE);
  assign handshake    = sample_valid && sample_ready;
  assign coef_write   = coef_we && (state_reg == IDLE);
  assign fir_we       = fir_we_reg;
  assign fir_waddr    = fir_waddr_reg;
  assign fir_wdata    = fir_wdata_reg;
  assign done         = done_reg;

  // Stored as the index of the final tap so the MAC state can stop on equality.
  always_comb begin
    last_next = '0;
    if (taps_cfg == '0) begin
      last_next = '0;
    end else if (taps_cfg > MAX_TAPS_L) begin
      last_next = IDX_W'(MAX_TAPS - 1);
    end else begin
      last_next = IDX_W'(taps_cfg - ONE_L);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_TAPS; gi++) begin : g_tap
      logic signed [DATA_W-1:0] d_reg;
      logic signed [DATA_W-1:0] c_reg;
      logic signed [DATA_W-1:0] d_in;

      if (gi == 0) begin : g_head
        assign d_in = sample_data;
      end else begin : g_body
        assign d_in = delay_arr[gi-1];
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          d_reg <= '0;
          c_reg <= '0;
        end else begin
          if (handshake) begin
            d_reg <= d_in;
          end
          if (coef_write && (coef_addr == IDX_W'(gi))) begin
            c_reg <= coef_wdata;
          end
        end
      end

      assign delay_arr[gi] = d_reg;
      assign coef_arr[gi]  = c_reg;
    end
  endgenerate

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear    (handshake),
    .enable   (state_reg == MAC),
    .coef     (coef_arr[idx_reg]),
    .sample   (delay_arr[idx_reg]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      last_reg      <= '0;
      dest_hold_reg <= '0;
      fir_we_reg    <= 1'b0;
      fir_waddr_reg <= '0;
      fir_wdata_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      fir_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            state_reg     <= MAC;
            idx_reg       <= '0;
            last_reg      <= last_next;
            dest_hold_reg <= dest_reg;
          end
        end
        MAC: begin
          idx_reg <= idx_reg + 1'b1;
          // The final tap's sum is taken straight from the adder so the write
          // lands in the cycle right after the last MAC edge.
          if (idx_reg == last_reg) begin
            state_reg <= WRITE;
            done_reg  <= 1'b1;
            if (dest_hold_reg != REG_X0) begin
              fir_we_reg    <= 1'b1;
              fir_waddr_reg <= dest_hold_reg;
              fir_wdata_reg <= DATA_W'(acc_next >>> OUT_SHIFT);
            end
          end
        end
        WRITE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_writeback.sv
// Scoreboard bench for fir_mac_writeback: stimulus pushes expected writes, a
// negedge monitor pops and checks them whenever done is presented.
module tb_fir_mac_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [31:0] coef_wdata;
  logic [3:0]  taps_cfg;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sample_data;
  logic [4:0]  dest_reg;
  logic        fir_we;
  logic [4:0]  fir_waddr;
  logic [31:0] fir_wdata;
  logic        busy;
  logic        done;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          started = 1'b0;
  bit          pend_ready = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  fir_mac_writeback dut (
    .clock        (clock),
    .reset        (reset),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .taps_cfg     (taps_cfg),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .dest_reg     (dest_reg),
    .fir_we       (fir_we),
    .fir_waddr    (fir_waddr),
    .fir_wdata    (fir_wdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    if (started && !reset) begin
      if (pend_ready) begin
        chk("ready_after_write", {63'd0, sample_ready}, 64'd1);
        pend_ready = 1'b0;
      end
      if (fir_we && !done) begin
        compared++;
        mismatched++;
        $display("FAIL we_without_done: fir_we=1 while done=0 (cycle %0d)", cyc);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: done pulsed with nothing outstanding (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("write: cycle=%0d fir_we=%0d x%0d <= 0x%08h", cyc, fir_we, fir_waddr, fir_wdata);
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("fir_we", {63'd0, fir_we}, {63'd0, e.we});
          chk("fir_waddr", {59'd0, fir_waddr}, {59'd0, e.addr});
          chk("fir_wdata", {32'd0, fir_wdata}, {32'd0, e.data});
          pend_ready = 1'b1;
        end
      end
    end
  end

  task automatic coef_write(input logic [2:0] a, input logic [31:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    @(posedge clock);
    #1 coef_we = 1'b0;
    $display("coef: coef[%0d] <= 0x%08h", a, d);
  endtask

  task automatic send(input logic [31:0] s, input logic [4:0] dst, input logic [3:0] taps,
                      input int t, input bit push, input logic [31:0] exp_d,
                      input bit cw, input logic [2:0] ca, input logic [31:0] cd);
    int   n;
    int   hs;
    exp_t e;
    n = 0;
    while (!sample_ready && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    if (!sample_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: sample_ready stayed 0 for 200 cycles");
    end
    sample_valid = 1'b1;
    sample_data  = s;
    dest_reg     = dst;
    taps_cfg     = taps;
    coef_we      = cw;
    coef_addr    = ca;
    coef_wdata   = cd;
    @(posedge clock);
    hs = cyc;
    #1;
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    $display("send: cycle=%0d sample=0x%08h dest=x%0d taps_cfg=%0d", hs, s, dst, taps);
    if (push) begin
      e.cyc = hs + t + 1;
      e.we  = (dst != 5'd0);
      if (e.we) begin
        last_addr = dst;
        last_data = exp_d;
      end
      e.addr = last_addr;
      e.data = last_data;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && sample_ready) && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d writes still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset        = 1'b1;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_wdata   = '0;
    taps_cfg     = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    dest_reg     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("ready_in_reset", {63'd0, sample_ready}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    started = 1'b1;
    @(negedge clock);
    chk("reset_ready", {63'd0, sample_ready}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_we_done", {62'd0, fir_we, done}, 64'd0);
    chk("reset_waddr", {59'd0, fir_waddr}, 64'd0);
    chk("reset_wdata", {32'd0, fir_wdata}, 64'd0);
    @(posedge clock);
    #1;

    // Coefs [1,2,3,4], four taps, three samples into x5.
    coef_write(3'd0, 32'd1);
    coef_write(3'd1, 32'd2);
    coef_write(3'd2, 32'd3);
    coef_write(3'd3, 32'd4);
    send(32'd10, 5'd5, 4'd4, 4, 1, 32'd10,  0, 3'd0, 32'd0);
    send(32'd20, 5'd5, 4'd4, 4, 1, 32'd40,  0, 3'd0, 32'd0);
    send(32'd30, 5'd5, 4'd4, 4, 1, 32'd100, 0, 3'd0, 32'd0);
    drain();

    // Signed single tap: -3 * 7 = -21.
    coef_write(3'd0, 32'hFFFF_FFFD);
    send(32'd7, 5'd9, 4'd1, 1, 1, 32'hFFFF_FFEB, 0, 3'd0, 32'd0);
    // x0 destination: -3 * 4, no write, outputs hold.
    send(32'd4, 5'd0, 4'd1, 1, 1, 32'd0, 0, 3'd0, 32'd0);
    // d=[2,4,7,30], coefs [-3,2,3,4]: 143; coef write while busy must be dropped.
    send(32'd2, 5'd3, 4'd4, 4, 1, 32'd143, 0, 3'd0, 32'd0);
    coef_write(3'd0, 32'd99);
    send(32'd1, 5'd4, 4'd1, 1, 1, 32'hFFFF_FFFD, 0, 3'd0, 32'd0);
    drain();

    // taps_cfg=0 acts as one tap; taps_cfg=15 clamps to eight.
    coef_write(3'd7, 32'd1000);
    send(32'd6, 5'd6, 4'd0, 1, 1, 32'hFFFF_FFEE, 0, 3'd0, 32'd0);
    send(32'd1, 5'd7, 4'd15, 8, 1, 32'd20020, 0, 3'd0, 32'd0);
    // Coefficient write coincident with the handshake is used by that sample.
    send(32'd3, 5'd8, 4'd1, 1, 1, 32'd15, 1, 3'd0, 32'd5);
    drain();

    // Reset in the middle of a four-tap MAC aborts it.
    send(32'd9, 5'd10, 4'd4, 4, 0, 32'd0, 0, 3'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("ready_during_reset", {63'd0, sample_ready}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    last_addr = '0;
    last_data = '0;
    @(negedge clock);
    chk("ready_after_reset", {63'd0, sample_ready}, 64'd1);
    chk("busy_after_reset", {63'd0, busy}, 64'd0);
    chk("waddr_after_reset", {59'd0, fir_waddr}, 64'd0);
    repeat (6) @(posedge clock);
    #1;
    send(32'd5, 5'd11, 4'd1, 1, 1, 32'd0, 0, 3'd0, 32'd0);
    drain();
    repeat (3) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
